conv_mac_responder: RTL and testbench

//  Convolution coprocessor that serves the execute stage's conv operation (ALUControl 3'b111).

---
 rtl/conv_mac_responder_if.sv | 48 ++++
 rtl/conv_mac_responder.sv | 212 +++++++++++++++++++++
 tb/tb_conv_mac_responder.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_mac_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_responder_if
// Description : Request/response bundle between the execute stage and the
//               convolution MAC coprocessor.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_mac_responder_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
);
    localparam int c_OP_W = LANES * DATA_W;

    logic              req_valid;
    logic              req_ready;
    logic [c_OP_W-1:0] req_a;
    logic [c_OP_W-1:0] req_b;
    logic [31:0]       req_bias;
    logic              req_relu;
    logic              req_last;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic              rsp_overflow;
    logic              rsp_zero;
    logic              rsp_negative;
    logic              rsp_truncated;
    logic [CNT_W-1:0]  rsp_beats;

    logic              busy;

    // Execute-stage side
    modport master (
        output req_valid, req_a, req_b, req_bias, req_relu, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_zero,
               rsp_negative, rsp_truncated, rsp_beats, busy
    );

    // Coprocessor side
    modport slave (
        input  req_valid, req_a, req_b, req_bias, req_relu, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_zero,
               rsp_negative, rsp_truncated, rsp_beats, busy
    );
endinterface
`default_nettype wire

// File: rtl/conv_mac_responder.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_responder
// Description : int8 dot-product accumulator onto a 32-bit bias, returning a
//               saturated, optionally ReLU'd result with ALU-style flags.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_responder #(
    parameter int LANES     = 4,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 40,
    parameter int MAX_BEATS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv_mac_responder_if.slave   bus
);

    localparam int c_PROD_W = 2 * DATA_W;
    localparam int c_PSUM_W = c_PROD_W + $clog2(LANES);
    localparam int c_CNT_W  = $clog2(MAX_BEATS + 1);

    localparam logic signed [ACC_W-1:0] c_ACC_MAX = {{(ACC_W-32){1'b0}}, 32'h7FFF_FFFF};
    localparam logic signed [ACC_W-1:0] c_ACC_MIN = {{(ACC_W-32){1'b1}}, 32'h8000_0000};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [c_PSUM_W-1:0] psum_q, psum_d;
    logic                       pipe_vld_q, pipe_vld_d;
    logic [c_CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic                       relu_q, relu_d;
    logic                       trunc_q, trunc_d;
    logic                       flush_cnt_q, flush_cnt_d;

    logic                       rsp_valid_q, rsp_valid_d;
    logic [31:0]                rsp_result_q, rsp_result_d;
    logic                       rsp_overflow_q, rsp_overflow_d;
    logic                       rsp_zero_q, rsp_zero_d;
    logic                       rsp_negative_q, rsp_negative_d;
    logic                       rsp_truncated_q, rsp_truncated_d;
    logic [c_CNT_W-1:0]         rsp_beats_q, rsp_beats_d;

    logic                       w_req_ready;
    logic                       w_accept;
    logic signed [c_PROD_W-1:0] w_prod [LANES];
    logic signed [c_PSUM_W-1:0] w_psum;
    logic [31:0]                w_sat;
    logic                       w_ovf;
    logic [31:0]                w_final;

    // Ready is gated by reset so nothing is accepted while it is held.
    assign w_req_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_ACCUM));
    assign w_accept    = bus.req_valid && w_req_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_prod[i] = c_PROD_W'($signed(bus.req_a[i*DATA_W +: DATA_W]))
                         * c_PROD_W'($signed(bus.req_b[i*DATA_W +: DATA_W]));
    end

    always_comb begin
        w_psum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_psum = w_psum + c_PSUM_W'(w_prod[i]);
        end
    end

    // Clamp to int32 first, then ReLU; the overflow flag survives ReLU.
    always_comb begin
        w_ovf = 1'b0;
        w_sat = acc_q[31:0];
        if (acc_q > c_ACC_MAX) begin
            w_sat = 32'h7FFF_FFFF;
            w_ovf = 1'b1;
        end else if (acc_q < c_ACC_MIN) begin
            w_sat = 32'h8000_0000;
            w_ovf = 1'b1;
        end
        w_final = (relu_q && w_sat[31]) ? 32'h0 : w_sat;
    end

    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        psum_d          = psum_q;
        pipe_vld_d      = w_accept;
        beat_cnt_d      = beat_cnt_q;
        relu_d          = relu_q;
        trunc_d         = trunc_q;
        flush_cnt_d     = 1'b0;
        rsp_valid_d     = rsp_valid_q;
        rsp_result_d    = rsp_result_q;
        rsp_overflow_d  = rsp_overflow_q;
        rsp_zero_d      = rsp_zero_q;
        rsp_negative_d  = rsp_negative_q;
        rsp_truncated_d = rsp_truncated_q;
        rsp_beats_d     = rsp_beats_q;

        if (pipe_vld_q) begin
            acc_d = acc_q + ACC_W'(psum_q);
        end
        if (w_accept) begin
            psum_d = w_psum;
        end

        unique case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    acc_d      = ACC_W'($signed(bus.req_bias));
                    relu_d     = bus.req_relu;
                    beat_cnt_d = c_CNT_W'(1);
                    trunc_d    = 1'b0;
                    state_d    = bus.req_last ? S_FLUSH : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept) begin
                    beat_cnt_d = beat_cnt_q + c_CNT_W'(1);
                    if (bus.req_last) begin
                        state_d = S_FLUSH;
                    end else if (beat_cnt_d == c_CNT_W'(MAX_BEATS)) begin
                        trunc_d = 1'b1;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Second FLUSH cycle: the final partial sum has landed in acc.
                flush_cnt_d = ~flush_cnt_q;
                if (flush_cnt_q) begin
                    state_d         = S_RESP;
                    rsp_valid_d     = 1'b1;
                    rsp_result_d    = w_final;
                    rsp_overflow_d  = w_ovf;
                    rsp_zero_d      = (w_final == 32'h0);
                    rsp_negative_d  = w_final[31];
                    rsp_truncated_d = trunc_q;
                    rsp_beats_d     = beat_cnt_q;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q           <= '0;
            psum_q          <= '0;
            pipe_vld_q      <= 1'b0;
            beat_cnt_q      <= '0;
            relu_q          <= 1'b0;
            trunc_q         <= 1'b0;
            flush_cnt_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_result_q    <= '0;
            rsp_overflow_q  <= 1'b0;
            rsp_zero_q      <= 1'b0;
            rsp_negative_q  <= 1'b0;
            rsp_truncated_q <= 1'b0;
            rsp_beats_q     <= '0;
        end else begin
            acc_q           <= acc_d;
            psum_q          <= psum_d;
            pipe_vld_q      <= pipe_vld_d;
            beat_cnt_q      <= beat_cnt_d;
            relu_q          <= relu_d;
            trunc_q         <= trunc_d;
            flush_cnt_q     <= flush_cnt_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_result_q    <= rsp_result_d;
            rsp_overflow_q  <= rsp_overflow_d;
            rsp_zero_q      <= rsp_zero_d;
            rsp_negative_q  <= rsp_negative_d;
            rsp_truncated_q <= rsp_truncated_d;
            rsp_beats_q     <= rsp_beats_d;
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_overflow  = rsp_overflow_q;
    assign bus.rsp_zero      = rsp_zero_q;
    assign bus.rsp_negative  = rsp_negative_q;
    assign bus.rsp_truncated = rsp_truncated_q;
    assign bus.rsp_beats     = rsp_beats_q;
    assign bus.busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_mac_responder
// Description : Randomized bench for conv_mac_responder with a longint
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_mac_responder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    conv_mac_responder_if bus ();

    conv_mac_responder #(
        .LANES(4), .DATA_W(8), .ACC_W(40), .MAX_BEATS(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {result, overflow, zero, negative, truncated, beats} for the beats in qa/qb
    function automatic logic [40:0] model(input logic [31:0] bias, input bit relu, input bit trunc);
        longint      s;
        longint      hi;
        longint      lo;
        logic [31:0] a, b, r;
        bit          ovf;
        hi  = 64'sd2147483647;
        lo  = -64'sd2147483648;
        s   = longint'($signed(bias));
        ovf = 1'b0;
        for (int i = 0; i < qa.size(); i++) begin
            a = qa[i];
            b = qb[i];
            for (int l = 0; l < 4; l++)
                s += longint'($signed(a[8*l +: 8])) * longint'($signed(b[8*l +: 8]));
        end
        if (s > hi)      begin r = 32'h7FFF_FFFF; ovf = 1'b1; end
        else if (s < lo) begin r = 32'h8000_0000; ovf = 1'b1; end
        else             r = s[31:0];
        if (relu && r[31]) r = 32'h0;
        return {r, ovf, (r == 32'h0), r[31], trunc, 5'(qa.size())};
    endfunction

    function automatic logic [40:0] observed();
        return {bus.rsp_result, bus.rsp_overflow, bus.rsp_zero, bus.rsp_negative,
                bus.rsp_truncated, bus.rsp_beats};
    endfunction

    // Streams qa/qb; lat = posedges from last accept until rsp_valid seen.
    task automatic run_txn(input logic [31:0] bias, input bit relu, input bit use_last,
                           input int gap_max, input bit wait_rsp, output int lat, output bit tmo);
        int n;
        n   = qa.size();
        lat = -1;
        tmo = 1'b0;
        for (int i = 0; i < n; i++) begin
            int gaps;
            int g;
            gaps = (gap_max > 0 && i > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int k = 0; k < gaps; k++) begin
                @(negedge clk);
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_a     = qa[i];
            bus.req_b     = qb[i];
            bus.req_bias  = (i == 0) ? bias : $urandom;
            bus.req_relu  = (i == 0) ? relu : 1'($urandom);
            bus.req_last  = use_last && (i == n - 1);
            g = 0;
            while (!bus.req_ready && g < 40) begin
                @(negedge clk);
                g++;
            end
            if (!bus.req_ready) tmo = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_last  = 1'b0;
        if (wait_rsp) begin
            int c;
            c = 1;
            while (!bus.rsp_valid && c < 40) begin
                @(negedge clk);
                c++;
            end
            if (bus.rsp_valid) lat = c - 1;
            else               tmo = 1'b1;
        end
    endtask

    task automatic release_rsp();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({observed(), bus.rsp_valid, bus.busy, bus.req_ready} !== 44'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 0", {observed(), bus.rsp_valid, bus.busy, bus.req_ready});
        end
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.req_ready, bus.busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_release: got ready/busy=%b want 10", {bus.req_ready, bus.busy});
        end
    endtask

    task automatic test_basic();
        logic [40:0] want;
        int          lat;
        bit          tmo;
        qa = {32'h0102_0304};
        qb = {32'h0101_0101};
        want = model(32'h0, 1'b0, 1'b0);
        run_txn(32'h0, 1'b0, 1'b1, 0, 1'b1, lat, tmo);
        vectors++;
        if (tmo || lat != 2) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d (timeout=%0d) want 2", lat, tmo);
        end
        vectors++;
        if (observed() !== want) begin
            miscompares++;
            $display("FAIL basic_rsp: got %h want %h", observed(), want);
        end
        vectors++;
        if (bus.rsp_result !== 32'd10) begin
            miscompares++;
            $display("FAIL basic_result: got %h want 0000000a", bus.rsp_result);
        end
        release_rsp();
        vectors++;
        if ({bus.rsp_valid, bus.busy, observed()} !== {2'b00, want}) begin
            miscompares++;
            $display("FAIL basic_after_handshake: got %h want %h", {bus.rsp_valid, bus.busy, observed()}, {2'b00, want});
        end
    endtask

    task automatic test_relu_negative();
        logic [40:0] want;
        int          lat;
        bit          tmo;
        for (int r = 0; r < 2; r++) begin
            qa = {32'hFFFF_FFFF};
            qb = {32'h7F7F_7F7F};
            want = model(32'h0, bit'(r), 1'b0);
            run_txn(32'h0, bit'(r), 1'b1, 0, 1'b1, lat, tmo);
            vectors++;
            if (tmo || observed() !== want) begin
                miscompares++;
                $display("FAIL relu%0d_rsp: got %h want %h (timeout=%0d)", r, observed(), want, tmo);
            end
            vectors++;
            if (bus.rsp_result !== ((r == 1) ? 32'h0 : 32'hFFFF_FE04)) begin
                miscompares++;
                $display("FAIL relu%0d_result: got %h", r, bus.rsp_result);
            end
            release_rsp();
        end
    endtask

    task automatic test_saturation();
        logic [31:0] t_bias [5];
        logic [31:0] t_a    [5];
        logic [31:0] t_b    [5];
        bit          t_relu [5];
        bit          t_ovf  [5];
        logic [40:0] want;
        int          lat;
        bit          tmo;
        t_bias = '{32'h7FFF_FFF0, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFF5, 32'h8000_000A};
        t_a    = '{32'h8080_8080, 32'h8080_8080, 32'h8080_8080, 32'h0102_0304, 32'h0102_0304};
        t_b    = '{32'h8080_8080, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h0101_0101, 32'hFFFF_FFFF};
        t_relu = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        t_ovf  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            qa = {t_a[i]};
            qb = {t_b[i]};
            want = model(t_bias[i], t_relu[i], 1'b0);
            run_txn(t_bias[i], t_relu[i], 1'b1, 0, 1'b1, lat, tmo);
            vectors++;
            if (tmo || observed() !== want) begin
                miscompares++;
                $display("FAIL sat%0d_rsp: got %h want %h (timeout=%0d)", i, observed(), want, tmo);
            end
            vectors++;
            if (bus.rsp_overflow !== t_ovf[i]) begin
                miscompares++;
                $display("FAIL sat%0d_overflow: got %b want %b", i, bus.rsp_overflow, t_ovf[i]);
            end
            release_rsp();
        end
    endtask

    task automatic test_gaps_backpressure();
        logic [40:0] want;
        logic [31:0] bias;
        int          lat;
        bit          tmo;
        qa.delete();
        qb.delete();
        for (int i = 0; i < 9; i++) begin
            qa.push_back($urandom);
            qb.push_back($urandom);
        end
        bias = $urandom;
        want = model(bias, 1'b0, 1'b0);
        run_txn(bias, 1'b0, 1'b1, 3, 1'b1, lat, tmo);
        vectors++;
        if (tmo || lat != 2) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d (timeout=%0d) want 2", lat, tmo);
        end
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({observed(), bus.rsp_valid, bus.req_ready} !== {want, 2'b10}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got %h want %h", c, {observed(), bus.rsp_valid, bus.req_ready}, {want, 2'b10});
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        vectors++;
        if (bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready_before_handshake: got %b want 0", bus.req_ready);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        vectors++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_ready_after_handshake: got ready/valid=%b want 10", {bus.req_ready, bus.rsp_valid});
        end
    endtask

    task automatic test_truncation();
        logic [40:0] want;
        logic [31:0] bias, a17, b17;
        int          lat;
        bit          tmo;
        int          c;
        qa.delete();
        qb.delete();
        for (int i = 0; i < 16; i++) begin
            qa.push_back($urandom);
            qb.push_back($urandom);
        end
        bias = $urandom;
        want = model(bias, 1'b1, 1'b1);
        run_txn(bias, 1'b1, 1'b0, 1, 1'b1, lat, tmo);
        vectors++;
        if (tmo || lat != 2 || observed() !== want) begin
            miscompares++;
            $display("FAIL trunc_rsp: got %h lat %0d want %h lat 2", observed(), lat, want);
        end
        a17 = $urandom;
        b17 = $urandom;
        bus.req_valid = 1'b1;
        bus.req_a     = a17;
        bus.req_b     = b17;
        bus.req_bias  = 32'h0;
        bus.req_relu  = 1'b0;
        bus.req_last  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({bus.req_ready, bus.rsp_valid} !== 2'b01) begin
                miscompares++;
                $display("FAIL trunc_17th_blocked%0d: got ready/valid=%b want 01", k, {bus.req_ready, bus.rsp_valid});
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL trunc_idle_ready: got %b want 1", bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_last  = 1'b0;
        c = 0;
        while (!bus.rsp_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        qa   = {a17};
        qb   = {b17};
        want = model(32'h0, 1'b0, 1'b0);
        vectors++;
        if (bus.rsp_valid !== 1'b1 || observed() !== want) begin
            miscompares++;
            $display("FAIL trunc_17th_txn: got valid %b rsp %h want %h", bus.rsp_valid, observed(), want);
        end
        release_rsp();
    endtask

    task automatic test_reset_midstream();
        logic [40:0] want;
        logic [31:0] bias;
        int          lat;
        bit          tmo;
        qa = {$urandom, $urandom, $urandom};
        qb = {$urandom, $urandom, $urandom};
        run_txn(32'h1234_5678, 1'b0, 1'b0, 0, 1'b0, lat, tmo);
        vectors++;
        if (tmo || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_accum_busy: got %b want 1", bus.busy);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({observed(), bus.rsp_valid, bus.busy, bus.req_ready} !== 44'h0) begin
            miscompares++;
            $display("FAIL rst_accum_outputs: got %h want 0", {observed(), bus.rsp_valid, bus.busy, bus.req_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        qa = {32'h7F7F_7F7F, 32'h7F7F_7F7F};
        qb = {32'h7F7F_7F7F, 32'h7F7F_7F7F};
        run_txn(32'h7654_3210, 1'b0, 1'b1, 0, 1'b1, lat, tmo);
        vectors++;
        if (tmo || bus.rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_resp_reached: got valid %b want 1", bus.rsp_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({observed(), bus.rsp_valid, bus.busy, bus.req_ready} !== 44'h0) begin
            miscompares++;
            $display("FAIL rst_resp_outputs: got %h want 0", {observed(), bus.rsp_valid, bus.busy, bus.req_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        qa   = {$urandom, $urandom};
        qb   = {$urandom, $urandom};
        bias = $urandom;
        want = model(bias, 1'b0, 1'b0);
        run_txn(bias, 1'b0, 1'b1, 0, 1'b1, lat, tmo);
        vectors++;
        if (tmo || observed() !== want) begin
            miscompares++;
            $display("FAIL rst_fresh_txn: got %h want %h (timeout=%0d)", observed(), want, tmo);
        end
        release_rsp();
    endtask

    task automatic test_random();
        logic [40:0] want;
        logic [31:0] bias;
        bit          relu, use_last;
        int          n, lat;
        bit          tmo;
        for (int t = 0; t < 12; t++) begin
            n        = int'($urandom_range(1, 16));
            use_last = (n < 16) ? 1'b1 : bit'($urandom_range(0, 1));
            relu     = bit'($urandom_range(0, 1));
            qa.delete();
            qb.delete();
            for (int i = 0; i < n; i++) begin
                qa.push_back($urandom);
                qb.push_back($urandom);
            end
            case ($urandom_range(0, 2))
                0:       bias = $urandom;
                1:       bias = 32'h7FFF_0000 + 32'($urandom_range(0, 65535));
                default: bias = 32'h8000_0000 + 32'($urandom_range(0, 65535));
            endcase
            want = model(bias, relu, !use_last);
            run_txn(bias, relu, use_last, 2, 1'b1, lat, tmo);
            vectors++;
            if (tmo || lat != 2) begin
                miscompares++;
                $display("FAIL rand%0d_latency: got %0d (timeout=%0d) want 2", t, lat, tmo);
            end
            vectors++;
            if (observed() !== want) begin
                miscompares++;
                $display("FAIL rand%0d_rsp: got %h want %h", t, observed(), want);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_rsp();
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_bias  = '0;
        bus.req_relu  = 1'b0;
        bus.req_last  = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_relu_negative();
        test_saturation();
        test_gaps_backpressure();
        test_truncation();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
